ahb_apb_bridge_param: RTL
=========================

// Module: ahb_apb_bridge_param
// PURPOSE
//  Parametrised AHB-lite slave to APB3 master bridge; successor to the fixed 3-slave bridge_top.
//  Adds a posted-write buffer, a configurable slave count, Pready wait states and Pslverr.
//  Sits between the AHB master and the APB peripheral group.
// PARAMETERS
//  DATA_W        32            data bus width (Hwdata/Hrdata/Pwdata/Prdata)
//  ADDR_W        32            address width
//  NUM_SLV       3             number of APB slaves (Pselx width), 1..16
//  BASE_ADDR     32'h8000_0000 base address of slave 0
//  SLV_SIZE_LOG2 26            log2 of each slave window (64 MB)
//  WBUF_DEPTH    4             posted-write FIFO entries, power of 2, >=2
// PORTS
//  Hclk        in   1        clock, all logic on rising edge
//  Hreset      in   1        asynchronous reset, active-high
//  Hreadyin    in   1        AHB bus ready (previous transfer complete)
//  Htrans      in   2        00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  Hwrite      in   1        1 write, 0 read
//  Haddr       in   ADDR_W   AHB address
//  Hwdata      in   DATA_W   AHB write data (data phase)
//  Hrdata      out  DATA_W   AHB read data, registered
//  Hreadyout   out  1        0 inserts a wait state in the current data phase
//  Hresp       out  2        00 OKAY, 01 ERROR
//  Pselx       out  NUM_SLV  one-hot APB select
//  Penable     out  1        APB ACCESS phase
//  Pwrite      out  1        APB direction
//  Paddr       out  ADDR_W   APB address
//  Pwdata      out  DATA_W   APB write data
//  Prdata      in   DATA_W   APB read data
//  Pready      in   1        APB slave ready
//  Pslverr     in   1        APB slave error, sampled with Pready
//  wr_err      out  1        sticky: a posted write got Pslverr; cleared only by reset
//  wbuf_count  out  clog2(WBUF_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0 except Hreadyout=1; Hresp=OKAY; FIFO emptied. Asserting Hreset mid-transfer aborts it at once.
//  Valid transfer: Hreadyin=1 and Htrans in {NONSEQ,SEQ}, captured at the address phase.
//  IDLE and BUSY transfers get a zero-wait OKAY and have no side effects.
//  Decode: idx=(Haddr-BASE_ADDR)>>SLV_SIZE_LOG2. A hit requires Haddr>=BASE_ADDR and idx<NUM_SLV.
//  Decode miss: no APB access, no FIFO push. Two-cycle ERROR: Hresp=01,Hreadyout=0, then Hresp=01,Hreadyout=1.
//  Write hit: {addr,Hwdata,idx} pushed at the end of the data phase. Zero wait if registered count<WBUF_DEPTH.
//  Write hit with FIFO full: Hreadyout=0 until the cycle after a pop. There is no same-cycle push/pop bypass when full.
//  Read hit: Hreadyout=0 while the FIFO drains (write-before-read ordering), then one APB read.
//    Hrdata<=Prdata on the Pready cycle; the next cycle Hreadyout=1 with OKAY, or the two-cycle ERROR if Pslverr=1.
//    Best case (FIFO empty, Pready=1): address cycle A; SETUP A+1; ACCESS A+2; Hreadyout=1 at A+3.
//  APB FSM states:
//    IDLE: go to SETUP when the FIFO is non-empty or a read is pending; the FIFO has priority.
//    SETUP: Pselx[idx]=1, Penable=0, Paddr/Pwrite/Pwdata valid. Always go to ACCESS next.
//    ACCESS: Penable=1, all APB outputs held stable. Stay while Pready=0.
//      On Pready=1: pop (write) or capture (read); a write with Pslverr=1 sets wr_err.
//      Then go to SETUP if more work is pending (Penable drops for one cycle), else IDLE with Pselx=0.
//  Pselx is one-hot or all zero; Penable=1 only when Pselx!=0.
//  FIFO pointers wrap modulo WBUF_DEPTH; wbuf_count ranges 0..WBUF_DEPTH and is never written past full.
//  A Pslverr on a posted write never causes an AHB ERROR; it is reported only through wr_err.
// TESTING
//  1 Write 0x8000_0010=0xA5A5_0001, Pready=1 -> zero wait; SETUP Pselx=001 next cycle, then ACCESS Pwdata=0xA5A5_0001.
//  2 INCR8 writes from 0x8400_0000, Pready 2 wait states -> beats 1-4 zero wait; beat 5 stalls until first pop;
//    8 APB writes on Pselx=010 in address order.
//  3 Two writes then read 0x8800_0004, Prdata=0x1234_5678 -> APB read starts only after wbuf_count=0;
//    Hrdata=0x1234_5678 with OKAY.
//  4 Read 0x8C00_0000 (NUM_SLV=3) -> Pselx stays 0; Hresp=01 for 2 cycles, Hreadyout 0 then 1.
//  5 Pslverr=1 on a read -> two-cycle ERROR. Pslverr=1 on a posted write -> wr_err=1 and Hresp stays OKAY.
//  6 Hreset asserted in ACCESS with 3 entries queued -> Pselx=0, Penable=0, wbuf_count=0, Hreadyout=1 immediately.

Source files
------------

// File: rtl/ahb_apb_bridge_param.sv
// AHB-lite slave to APB3 master bridge with a posted-write FIFO,
// a parameterised slave count, Pready wait states and Pslverr reporting.
module ahb_apb_bridge_param #(
    parameter int unsigned        DATA_W        = 32,
    parameter int unsigned        ADDR_W        = 32,
    parameter int unsigned        NUM_SLV       = 3,
    parameter logic [ADDR_W-1:0]  BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned        SLV_SIZE_LOG2 = 26,
    parameter int unsigned        WBUF_DEPTH    = 4
) (
    input  logic                          Hclk,
    input  logic                          Hreset,
    input  logic                          Hreadyin,
    input  logic [1:0]                    Htrans,
    input  logic                          Hwrite,
    input  logic [ADDR_W-1:0]             Haddr,
    input  logic [DATA_W-1:0]             Hwdata,
    output logic [DATA_W-1:0]             Hrdata,
    output logic                          Hreadyout,
    output logic [1:0]                    Hresp,
    output logic [NUM_SLV-1:0]            Pselx,
    output logic                          Penable,
    output logic                          Pwrite,
    output logic [ADDR_W-1:0]             Paddr,
    output logic [DATA_W-1:0]             Pwdata,
    input  logic [DATA_W-1:0]             Prdata,
    input  logic                          Pready,
    input  logic                          Pslverr,
    output logic                          wr_err,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W + IDX_W;

    // AHB data-phase state and APB master state
    typedef enum logic [2:0] {D_IDLE, D_WRITE, D_READ, D_RDONE, D_ERR1, D_ERR2} dph_t;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_t;

    dph_t               dph_q, dph_d;
    apb_t               apb_q, apb_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  hrdata_q, hrdata_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               wr_err_q, wr_err_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
    logic [CNT_W-1:0]   count_q, count_d, remaining;
    logic [ENT_W-1:0]   mem_q [WBUF_DEPTH];

    // Address decode of the current AHB address phase
    logic [ADDR_W-1:0]  off, slot;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_hit, htrans_valid, hready, accept;
    assign off          = Haddr - BASE_ADDR;
    assign slot         = off >> SLV_SIZE_LOG2;
    assign dec_hit      = (Haddr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLV));
    assign dec_idx      = slot[IDX_W-1:0];
    assign htrans_valid = (Htrans == 2'b10) || (Htrans == 2'b11);

    // Data phase completes this cycle unless a read, an error, or a full-FIFO write is stalling
    logic fifo_full, push, pop, rd_done, new_rd, rd_req, fifo_avail;
    assign fifo_full = (count_q >= CNT_W'(WBUF_DEPTH));
    assign hready    = (dph_q == D_IDLE) || (dph_q == D_RDONE) || (dph_q == D_ERR2) ||
                       ((dph_q == D_WRITE) && !fifo_full);
    assign accept    = hready && Hreadyin && htrans_valid;
    assign push      = (dph_q == D_WRITE) && !fifo_full;
    assign pop       = (apb_q == A_ACCESS) && Pready && pwrite_q;
    assign rd_done   = (apb_q == A_ACCESS) && Pready && !pwrite_q;
    assign new_rd    = accept && dec_hit && !Hwrite;
    assign rd_req    = (dph_q == D_READ) || new_rd;

    // FIFO head after this cycle's pop; an empty FIFO forwards the entry being pushed
    logic [ADDR_W-1:0]  h_addr, m_addr, rd_addr;
    logic [DATA_W-1:0]  h_data, m_data;
    logic [IDX_W-1:0]   h_idx, m_idx, rd_idx;
    assign nxt_ptr    = rd_ptr_q + PTR_W'(pop);
    assign remaining  = count_q - CNT_W'(pop);
    assign fifo_avail = (remaining != '0) || push;
    assign {m_addr, m_data, m_idx} = mem_q[nxt_ptr];
    assign h_addr     = (remaining != '0) ? m_addr : addr_q;
    assign h_data     = (remaining != '0) ? m_data : Hwdata;
    assign h_idx      = (remaining != '0) ? m_idx  : idx_q;
    assign rd_addr    = (dph_q == D_READ) ? addr_q : Haddr;
    assign rd_idx     = (dph_q == D_READ) ? idx_q  : dec_idx;

    // AHB data-phase next state, address capture and read-data capture
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        dph_d    = dph_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        hrdata_d = rd_done ? Prdata : hrdata_q;
        if (hready) begin
            dph_d = D_IDLE;
            if (accept) begin
                addr_d = Haddr;
                idx_d  = dec_idx;
                if (!dec_hit)    dph_d = D_ERR1;
                else if (Hwrite) dph_d = D_WRITE;
                else             dph_d = D_READ;
            end
        end else if (dph_q == D_ERR1) begin
            dph_d = D_ERR2;
        end else if ((dph_q == D_READ) && rd_done) begin
            dph_d = Pslverr ? D_ERR1 : D_RDONE;
        end
    end

    // APB master next state; the FIFO always wins over a pending read
    always_comb begin
        logic load;
        apb_d     = apb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        wr_err_d  = wr_err_q;
        load      = 1'b0;
        case (apb_q)
            A_IDLE:   load = fifo_avail || rd_req;
            A_SETUP: begin
                apb_d     = A_ACCESS;
                penable_d = 1'b1;
            end
            A_ACCESS: begin
                if (Pready) begin
                    penable_d = 1'b0;
                    if (pwrite_q && Pslverr) wr_err_d = 1'b1;
                    if (fifo_avail || (pwrite_q && rd_req)) begin
                        load = 1'b1;
                    end else begin
                        apb_d  = A_IDLE;
                        psel_d = '0;
                    end
                end
            end
            default:  apb_d = A_IDLE;
        endcase
        if (load) begin
            apb_d     = A_SETUP;
            penable_d = 1'b0;
            if (fifo_avail) begin
                pwrite_d = 1'b1;
                paddr_d  = h_addr;
                pwdata_d = h_data;
                psel_d   = NUM_SLV'(1) << h_idx;
            end else begin
                pwrite_d = 1'b0;
                paddr_d  = rd_addr;
                psel_d   = NUM_SLV'(1) << rd_idx;
            end
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = nxt_ptr;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control and output registers, cleared by reset
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            dph_q     <= D_IDLE;
            apb_q     <= A_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            hrdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            wr_err_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            dph_q     <= dph_d;
            apb_q     <= apb_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            hrdata_q  <= hrdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            wr_err_q  <= wr_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage
    always_ff @(posedge Hclk) begin
        // NOTE: storage is not reset; count_q alone decides which entries are valid.
        if (push) mem_q[wr_ptr_q] <= {addr_q, Hwdata, idx_q};
    end

    assign Hrdata     = hrdata_q;
    assign Hreadyout  = hready;
    assign Hresp      = {1'b0, (dph_q == D_ERR1) || (dph_q == D_ERR2)};
    assign Pselx      = psel_q;
    assign Penable    = penable_q;
    assign Pwrite     = pwrite_q;
    assign Paddr      = paddr_q;
    assign Pwdata     = pwdata_q;
    assign wr_err     = wr_err_q;
    assign wbuf_count = count_q;

endmodule
